mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arb_timer.sv | 37 +++
 rtl/mem_port_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default parameters for the fetch/data memory port arbiter.
//   state_t : arbiter FSM states (IDLE, BUSY_IF, BUSY_D)
//   owner_t : which requester owns the memory port
//   DEF_MAX_WAIT / DEF_TIMEOUT : default starvation limit and abort timeout
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam int DEF_MAX_WAIT = 4;
    localparam int DEF_TIMEOUT  = 16;

endpackage

// File: rtl/mem_arb_timer.sv
// Transaction timeout counter.
// Counts cycles in which enable is high; expire is asserted combinationally
// during the cycle whose edge would make the count reach TIMEOUT.
//   clk    in  clock, rising edge
//   rst    in  asynchronous active-high reset
//   clear  in  synchronous clear (takes priority over enable)
//   enable in  count this cycle
//   expire out TIMEOUT-th enabled cycle since the last clear
module mem_arb_timer
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_count;

    assign expire = enable && !clear && (r_count == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear || expire) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single memory port between an instruction-fetch requester and
// a data requester. Data normally has priority; after MAX_WAIT consecutive
// data wins against a pending fetch, the fetch is forced through. A busy
// transaction is aborted with err after TIMEOUT cycles without mem_ready.
//   if_req/if_addr                       fetch request in
//   if_gnt/if_rvalid/if_rdata            fetch accept, done, instruction out
//   d_req/d_addr/d_wdata/d_wren          data request in (wren!=0 => write)
//   d_gnt/d_rvalid/d_rdata               data accept, done, load data out
//   mem_req/mem_addr/mem_wdata/mem_wren  shared memory port out
//   mem_ready/mem_rdata                  memory completion and read data in
//   busy/err                             not idle; timeout abort pulse
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wren,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wren,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        err
);

    localparam int WW = $clog2(MAX_WAIT + 1);

    state_t        r_state, w_state_next;
    logic [WW-1:0] r_wait_cnt, w_wait_next;
    logic          r_if_gnt, r_d_gnt, r_if_rvalid, r_d_rvalid, r_mem_req, r_busy, r_err;
    logic          w_if_gnt_next, w_d_gnt_next, w_if_rvalid_next, w_d_rvalid_next;
    logic          w_mem_req_next, w_err_next;
    logic [31:0]   r_if_rdata, r_d_rdata, r_mem_addr, r_mem_wdata;
    logic [31:0]   w_if_rdata_next, w_d_rdata_next, w_mem_addr_next, w_mem_wdata_next;
    logic [3:0]    r_mem_wren, w_mem_wren_next;
    owner_t        w_winner;
    logic          w_expire;

    // Timer only runs while a transaction is outstanding and memory is stalling.
    mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (r_state == IDLE),
        .enable ((r_state != IDLE) && !mem_ready),
        .expire (w_expire)
    );

    always_comb begin
        w_state_next     = r_state;
        w_wait_next      = r_wait_cnt;
        w_if_gnt_next    = 1'b0;
        w_d_gnt_next     = 1'b0;
        w_if_rvalid_next = 1'b0;
        w_d_rvalid_next  = 1'b0;
        w_err_next       = 1'b0;
        w_mem_req_next   = r_mem_req;
        w_mem_addr_next  = r_mem_addr;
        w_mem_wdata_next = r_mem_wdata;
        w_mem_wren_next  = r_mem_wren;
        w_if_rdata_next  = r_if_rdata;
        w_d_rdata_next   = r_d_rdata;
        w_winner         = OWN_IF;

        case (r_state)
            IDLE: begin
                if (if_req || d_req) begin
                    if (d_req && !(if_req && r_wait_cnt == WW'(MAX_WAIT)))
                        w_winner = OWN_D;
                    else
                        w_winner = OWN_IF;

                    w_mem_req_next = 1'b1;
                    if (w_winner == OWN_D) begin
                        w_state_next     = BUSY_D;
                        w_d_gnt_next     = 1'b1;
                        w_mem_addr_next  = d_addr;
                        w_mem_wdata_next = d_wdata;
                        w_mem_wren_next  = d_wren;
                        // Data can only beat a fetch while below the limit, so no overflow here.
                        if (if_req)
                            w_wait_next = r_wait_cnt + 1'b1;
                    end else begin
                        w_state_next     = BUSY_IF;
                        w_if_gnt_next    = 1'b1;
                        w_mem_addr_next  = if_addr;
                        w_mem_wdata_next = '0;
                        w_mem_wren_next  = '0;
                        w_wait_next      = '0;
                    end
                end
            end
            BUSY_IF, BUSY_D: begin
                if (mem_ready || w_expire) begin
                    w_state_next   = IDLE;
                    w_mem_req_next = 1'b0;
                    w_err_next     = !mem_ready;
                    if (r_state == BUSY_IF) begin
                        w_if_rvalid_next = 1'b1;
                        if (mem_ready)
                            w_if_rdata_next = mem_rdata;
                    end else begin
                        w_d_rvalid_next = 1'b1;
                        if (mem_ready && r_mem_wren == 4'd0)
                            w_d_rdata_next = mem_rdata;
                    end
                end
            end
            default: begin
                w_state_next   = IDLE;
                w_mem_req_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_wait_cnt  <= '0;
            r_if_gnt    <= 1'b0;
            r_d_gnt     <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wren  <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_state     <= w_state_next;
            r_wait_cnt  <= w_wait_next;
            r_if_gnt    <= w_if_gnt_next;
            r_d_gnt     <= w_d_gnt_next;
            r_if_rvalid <= w_if_rvalid_next;
            r_d_rvalid  <= w_d_rvalid_next;
            r_err       <= w_err_next;
            r_busy      <= (w_state_next != IDLE);
            r_mem_req   <= w_mem_req_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_wdata <= w_mem_wdata_next;
            r_mem_wren  <= w_mem_wren_next;
            r_if_rdata  <= w_if_rdata_next;
            r_d_rdata   <= w_d_rdata_next;
        end
    end

    assign if_gnt    = r_if_gnt;
    assign if_rvalid = r_if_rvalid;
    assign if_rdata  = r_if_rdata;
    assign d_gnt     = r_d_gnt;
    assign d_rvalid  = r_d_rvalid;
    assign d_rdata   = r_d_rdata;
    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wren  = r_mem_wren;
    assign busy      = r_busy;
    assign err       = r_err;

endmodule
